// File: rtl/prod_accum.sv
// rtl/prod_accum.sv - packet accumulator for 16-bit products with saturating sum/count and held result
module prod_accum #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      prod,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    // One extra bit on the adder exposes the carry that signals saturation.
    logic [ACC_W:0]     sum_wide;
    logic               sum_carry;
    logic [ACC_W-1:0]   acc_sat;
    logic [CNT_W-1:0]   cnt_inc;
    logic               beat_acc;

    // Saturating add of the incoming product and saturating beat count.
    always_comb begin
        sum_wide  = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, prod};
        sum_carry = sum_wide[ACC_W];
        acc_sat   = sum_carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
        cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q
                                              : cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
        // clr overrides any beat presented in the same cycle.
        beat_acc  = in_valid & in_ready_q & ~clr;
    end

    // Next-state and output-register logic; clr takes priority over everything.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (clr) begin
            state_d     = ST_IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
            out_sum_d   = '0;
            out_count_d = '0;
            out_ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_ACC: begin
                    if (beat_acc) begin
                        if (in_last) begin
                            // Packet closes: publish the result and restart the accumulator.
                            out_sum_d   = acc_sat;
                            out_count_d = cnt_inc;
                            out_ovf_d   = ovf_q | sum_carry;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                            cnt_d       = '0;
                            ovf_d       = 1'b0;
                            state_d     = ST_HOLD;
                        end else begin
                            acc_d   = acc_sat;
                            cnt_d   = cnt_inc;
                            ovf_d   = ovf_q | sum_carry;
                            state_d = ST_ACC;
                        end
                    end
                end
                ST_HOLD: begin
                    // Result is retired only by the consumer; no bypass into a new packet.
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Ready is registered: it reflects the state the block is about to be in.
        in_ready_d = (state_d != ST_HOLD);
    end

    // State and output registers with asynchronous clear to the idle/empty condition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter ACC_W, 24, accumulator and result width in bits (ACC_W >= 17).
REQ-002 Parameter CNT_W, 8, beat-counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 prod  input  16  unsigned product from the 8x8 array multiplier.
REQ-006 in_valid  input  1  prod/in_last qualify this cycle.
REQ-007 in_last  input  1  current beat ends the packet (dot product).
REQ-008 in_ready  output  1  block accepts a beat this cycle; registered.
REQ-009 clr  input  1  synchronous abort of the current packet or held result.
REQ-010 out_valid  output  1  result held on out_sum/out_count/out_ovf; registered.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_sum  output  ACC_W  accumulated packet sum; registered.
REQ-013 out_count  output  CNT_W  beats in the packet; registered.
REQ-014 out_ovf  output  1  accumulator saturated during the packet; registered.

Function
REQ-015 The block SHALL use three states: IDLE (acc=0, cnt=0), ACC (partial packet), HOLD (result presented).
REQ-016 A beat SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; other cycles leave the accumulator unchanged.
REQ-017 in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD; it SHALL drop on the cycle after the in_last beat is accepted.
REQ-018 An accepted beat SHALL add zero-extended prod to acc and increment cnt; IDLE->ACC on a non-last beat.
REQ-019 Sums exceeding 2^ACC_W-1 SHALL saturate acc to all ones and set the packet overflow flag, which stays set until the packet ends.
REQ-020 cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-021 An accepted beat with in_last=1 (from IDLE or ACC) SHALL load out_sum=acc+prod (saturated), out_count=cnt+1 (saturated), and out_ovf, then enter HOLD with out_valid=1 on the next cycle.
REQ-022 The latency from last-beat acceptance to out_valid SHALL be exactly 1 cycle.
REQ-023 On entering HOLD, acc, cnt and the internal overflow flag SHALL clear to 0.
REQ-024 In HOLD, out_sum/out_count/out_ovf SHALL stay stable until out_valid=1 and out_ready=1.
REQ-025 The HOLD handshake SHALL take HOLD->IDLE, with out_valid=0 and in_ready=1 on the next cycle; there is no same-cycle bypass.
REQ-026 out_ready SHALL be ignored outside HOLD.
REQ-027 clr=1 SHALL win over any beat or out handshake in the same cycle.
REQ-028 clr=1 SHALL discard acc/cnt/overflow and go to IDLE next cycle; in HOLD it SHALL also drop out_valid, and out_sum/out_count/out_ovf SHALL clear to 0.
REQ-029 prod SHALL be treated as don't-care when in_valid=0.

Reset
REQ-030 While rst=1, all state SHALL be forced immediately, regardless of clk: state=IDLE, acc=0, cnt=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=0.
REQ-031 in_ready SHALL rise on the first clk edge after rst deasserts.
REQ-032 rst asserted mid-packet or in HOLD SHALL discard all partial and held data.

Verification
REQ-033 Beats 0x0006, 0x0014, 0xFE01 (last) back-to-back -> one cycle later out_valid=1, out_sum=0x00FE1B, out_count=3, out_ovf=0; in_ready=0 until the handshake.
REQ-034 Single beat 0xFE01 with in_last from IDLE -> next cycle out_sum=0x00FE01, out_count=1.
REQ-035 257 beats of 0xFFFF, the last with in_last -> out_sum=0xFFFFFF, out_count=255, out_ovf=1; next packet of 0x0001 (last) -> out_sum=1, out_ovf=0.
REQ-036 Result held with out_ready=0 for 5 cycles while in_valid=1 -> outputs stable, no beat accepted; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
REQ-037 Beats 0x0100, 0x0200, then clr=1 together with a valid 0x0300 beat -> beat ignored, IDLE; then 0x0005 (last) -> out_sum=0x000005, out_count=1.
REQ-038 rst pulsed between clk edges while in HOLD -> out_valid, out_sum, out_count fall to 0 immediately; in_ready=1 after the first edge following release.
